// File: rtl/serial_in.sv
// Oversampled serial write port: deserialises MSB-first words from an external
// host (sSCLK/sMOSI framed by sCS_n) and writes them to consecutive SRAM addresses.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no frame; serial clock edges ignored, waiting for sCS_n fall
// SHIFT | frame active, assembling a word bit by bit
// WRITE | single cycle: wen asserted with the assembled word and address
// FULL  | LAST_ADDR written; further bits ignored until frame end
module serial_in #(
  parameter int                WORD_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] LAST_ADDR = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sSCLK,
  input  logic              sMOSI,
  input  logic              sCS_n,
  output logic              wen,
  output logic [ADDR_W-1:0] addr,
  output logic [WORD_W-1:0] wdata,
  output logic              busy,
  output logic              full,
  output logic              done,
  output logic              err
);

  localparam int BCW = $clog2(WORD_W + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE, FULL} state_t;

  state_t            state;
  logic [BCW-1:0]    bit_cnt;
  logic [WORD_W-1:0] shreg;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic mosi_s1, mosi_s2;
  logic cs_s1, cs_s2, cs_s3;

  // Synchroniser flops come out of reset at the pins' idle levels so that
  // releasing reset never looks like a clock or frame edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
    end else begin
      sclk_s1 <= sSCLK;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= sMOSI;
      mosi_s2 <= mosi_s1;
      cs_s1   <= sCS_n;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
    end
  end

  logic              sclk_rise, cs_fall, cs_rise;
  logic [WORD_W-1:0] shift_nxt;

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign cs_fall   = ~cs_s2 & cs_s3;
  assign cs_rise   = cs_s2 & ~cs_s3;
  assign shift_nxt = {shreg[WORD_W-2:0], mosi_s2};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      wen     <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      busy    <= 1'b0;
      full    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      wen  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            addr    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            full    <= 1'b0;
            err     <= 1'b0;
          end
        end
        SHIFT: begin
          // Frame end wins over a coincident bit edge; a partial word is dropped.
          if (cs_rise) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            bit_cnt <= '0;
            if (bit_cnt != '0) err <= 1'b1;
          end else if (sclk_rise) begin
            shreg   <= shift_nxt;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= WRITE;
              wen   <= 1'b1;
              wdata <= shift_nxt;
            end
          end
        end
        WRITE: begin
          bit_cnt <= '0;
          if (addr == LAST_ADDR) begin
            full  <= 1'b1;
            state <= FULL;
          end else begin
            addr  <= addr + 1'b1;
            state <= SHIFT;
          end
          // The write in flight completes; done lands on the following cycle.
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FULL: begin
          if (cs_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_in.sv
// Scoreboard bench for serial_in: two instances (full address range and
// LAST_ADDR=3) share the serial pins; monitors pop expected writes on wen.
`timescale 1ns/1ps
module tb_serial_in;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sSCLK = 1'b0;
  logic sMOSI = 1'b0;
  logic sCS_n = 1'b1;

  logic        wen_a, busy_a, full_a, done_a, err_a;
  logic [15:0] addr_a, wdata_a;
  logic        wen_b, busy_b, full_b, done_b, err_b;
  logic [15:0] addr_b, wdata_b;

  serial_in dut_a (
    .clk(clk), .rst(rst), .sSCLK(sSCLK), .sMOSI(sMOSI), .sCS_n(sCS_n),
    .wen(wen_a), .addr(addr_a), .wdata(wdata_a),
    .busy(busy_a), .full(full_a), .done(done_a), .err(err_a)
  );

  serial_in #(.LAST_ADDR(16'd3)) dut_b (
    .clk(clk), .rst(rst), .sSCLK(sSCLK), .sMOSI(sMOSI), .sCS_n(sCS_n),
    .wen(wen_b), .addr(addr_b), .wdata(wdata_b),
    .busy(busy_b), .full(full_b), .done(done_b), .err(err_b)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_a_cnt = 0;
  int done_b_cnt = 0;
  int last_wen_cyc = 0;
  int last_done_cyc = 0;
  logic prev_wen_a = 1'b0;
  logic prev_wen_b = 1'b0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_a();
    logic [31:0] e;
    if (wen_a) begin
      check("a_wen_width", 64'(prev_wen_a), 64'd0);
      if (q_a.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL a_unexpected_wen: got addr %0h data %0h, expected no write", addr_a, wdata_a);
      end else begin
        e = q_a.pop_front();
        check("a_write", 64'({addr_a, wdata_a}), 64'(e));
      end
      last_wen_cyc = cyc;
    end
    if (done_a) begin
      done_a_cnt++;
      last_done_cyc = cyc;
    end
  endtask

  task automatic mon_b();
    logic [31:0] e;
    if (wen_b) begin
      check("b_wen_width", 64'(prev_wen_b), 64'd0);
      if (q_b.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_unexpected_wen: got addr %0h data %0h, expected no write", addr_b, wdata_b);
      end else begin
        e = q_b.pop_front();
        check("b_write", 64'({addr_b, wdata_b}), 64'(e));
      end
    end
    if (done_b) done_b_cnt++;
  endtask

  always @(negedge clk) begin
    mon_a();
    mon_b();
    prev_wen_a <= wen_a;
    prev_wen_b <= wen_b;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sMOSI = b;
    tick(5);
    sSCLK = 1'b1;
    tick(5);
    sSCLK = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic expect_word(input int idx, input logic [15:0] w);
    q_a.push_back({16'(idx), w});
    if (idx <= 3) q_b.push_back({16'(idx), w});
  endtask

  task automatic start_frame();
    sCS_n = 1'b0;
    tick(6);
    check("busy_in_frame", 64'(busy_a), 64'd1);
  endtask

  task automatic wait_done(input string tag, input logic e_err, input logic e_full_b);
    int base;
    bit seen;
    base = done_a_cnt;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick(1);
      if (done_a) begin
        seen = 1;
        check({tag, "_err_a"}, 64'(err_a), 64'(e_err));
        check({tag, "_err_b"}, 64'(err_b), 64'(e_err));
        check({tag, "_full_a"}, 64'(full_a), 64'd0);
        check({tag, "_full_b"}, 64'(full_b), 64'(e_full_b));
        check({tag, "_done_b"}, 64'(done_b), 64'd1);
        check({tag, "_busy_off"}, 64'(busy_a), 64'd0);
      end
    end
    if (!seen) check({tag, "_done_timeout"}, 64'd0, 64'd1);
    tick(3);
    check({tag, "_done_count"}, 64'(done_a_cnt - base), 64'd1);
  endtask

  task automatic end_frame(input string tag, input logic e_err, input logic e_full_b);
    tick(4);
    sCS_n = 1'b1;
    wait_done(tag, e_err, e_full_b);
  endtask

  logic [15:0] w;
  int          done_base;

  initial begin
    tick(3);
    check("reset_a", 64'({wen_a, addr_a, wdata_a, busy_a, full_a, done_a, err_a}), 64'd0);
    check("reset_b", 64'({wen_b, addr_b, wdata_b, busy_b, full_b, done_b, err_b}), 64'd0);
    rst = 1'b1;
    tick(3);

    // serial clock with no frame select
    done_base = done_a_cnt;
    for (int i = 0; i < 20; i++) send_bit(i[0]);
    tick(4);
    check("idle_busy", 64'(busy_a), 64'd0);
    check("idle_no_done", 64'(done_a_cnt - done_base), 64'd0);

    // three-word frame
    start_frame();
    expect_word(0, 16'h1234); send_word(16'h1234);
    expect_word(1, 16'hABCD); send_word(16'hABCD);
    expect_word(2, 16'h0001); send_word(16'h0001);
    end_frame("three_words", 1'b0, 1'b0);

    // six words: dut_b fills at addr 3
    start_frame();
    for (int k = 0; k < 6; k++) begin
      w = 16'h1111 * 16'(k + 1);
      expect_word(k, w);
      send_word(w);
      if (k == 3) begin
        check("full_b_after_4th", 64'(full_b), 64'd1);
        check("full_a_after_4th", 64'(full_a), 64'd0);
        check("busy_b_in_full", 64'(busy_b), 64'd1);
      end
    end
    end_frame("six_words", 1'b0, 1'b1);
    tick(5);
    check("full_b_persists", 64'(full_b), 64'd1);
    check("addr_b_held", 64'(addr_b), 64'd3);

    // one word plus seven stray bits
    start_frame();
    check("full_b_cleared", 64'(full_b), 64'd0);
    expect_word(0, 16'hA55A); send_word(16'hA55A);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    end_frame("partial", 1'b1, 1'b0);

    start_frame();
    check("err_cleared", 64'(err_a), 64'd0);
    expect_word(0, 16'hFFFF); send_word(16'hFFFF);
    end_frame("after_partial", 1'b0, 1'b0);

    // frame select rises while the last bit edge becomes a write
    start_frame();
    w = 16'hC3A5;
    expect_word(0, w);
    for (int i = 15; i >= 1; i--) send_bit(w[i]);
    sMOSI = w[0];
    tick(5);
    sSCLK = 1'b1;
    tick(1);
    sCS_n = 1'b1;
    wait_done("cs_at_write", 1'b0, 1'b0);
    check("done_after_wen", 64'(last_done_cyc - last_wen_cyc), 64'd1);
    sSCLK = 1'b0;
    tick(4);

    // reset in the middle of the second word
    start_frame();
    expect_word(0, 16'h5A5A); send_word(16'h5A5A);
    for (int i = 0; i < 9; i++) send_bit(i[0]);
    rst = 1'b0;
    #1;
    check("midreset_a", 64'({wen_a, addr_a, wdata_a, busy_a, full_a, done_a, err_a}), 64'd0);
    check("midreset_b", 64'({wen_b, addr_b, wdata_b, busy_b, full_b, done_b, err_b}), 64'd0);
    sCS_n = 1'b1;
    sSCLK = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(3);
    start_frame();
    expect_word(0, 16'h0F0F); send_word(16'h0F0F);
    end_frame("after_reset", 1'b0, 1'b0);

    tick(5);
    check("queue_a_drained", 64'(q_a.size()), 64'd0);
    check("queue_b_drained", 64'(q_b.size()), 64'd0);
    check("done_total_a", 64'(done_a_cnt), 64'd6);
    check("done_total_b", 64'(done_b_cnt), 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
